player_bullet_ctrl: RTL and testbench



---
 rtl/galaga_pkg.sv | 23 ++
 rtl/player_bullet_ctrl_free_slot_finder.sv | 30 +++
 rtl/player_bullet_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_player_bullet_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/galaga_pkg.sv
// -----------------------------------------------------------------------------
// galaga_pkg
// Shared geometry constants and the player-bullet FSM state type.
// No ports; imported by player_bullet_ctrl and by the bench.
// -----------------------------------------------------------------------------
package galaga_pkg;

  localparam int SLOT_W        = 19;   // packed bits per bullet slot: {y[8:0], x[9:0]}
  localparam int X_W           = 10;
  localparam int Y_W           = 9;
  localparam int PLAYER_Y      = 280;  // player sprite top row
  localparam int PLAYER_WIDTH  = 24;
  localparam int BULLET_WIDTH  = 4;
  localparam int BULLET_HEIGHT = 16;
  localparam int SCREEN_W      = 640;

  typedef enum logic [1:0] {
    S_READY    = 2'd0,  // a pending shot may spawn on the next tick
    S_COOLDOWN = 2'd1,  // counting frames after an accepted shot
    S_DEAD     = 2'd2   // player not alive: no new shots
  } bullet_fsm_e;

endpackage

// File: rtl/player_bullet_ctrl_free_slot_finder.sv
// -----------------------------------------------------------------------------
// free_slot_finder
// Combinational priority encoder: reports the lowest-index set bit of i_free.
// Ports:
//   i_free  [N]      candidate slots (1 = usable)
//   o_found          at least one candidate exists
//   o_idx   [IDX_W]  index of the lowest candidate (0 when none)
// -----------------------------------------------------------------------------
module free_slot_finder #(
  parameter int N     = 15,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_free,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_free[i]) begin
        o_found = 1'b1;
        o_idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/player_bullet_ctrl.sv
// -----------------------------------------------------------------------------
// player_bullet_ctrl
// Owns the pool of player bullets: accepts fire requests, allocates the lowest
// free slot, enforces a per-shot cooldown, moves bullets up once per frame and
// retires them at the top edge or on a collision clear.
//
// Optional build macro: PLAYER_BULLET_AUTOFIRE_EN
//   defined   -> fire level (held button) requests a shot whenever READY
//   undefined -> only a rising edge of fire requests a shot
//
// Ports:
//   clk                   system clock
//   rst_n                 synchronous active-low reset
//   frame_tick            one-cycle pulse per video frame
//   fire                  fire button level (already synchronised)
//   playerState           1 = player alive
//   playerPosition [10]   player left x
//   hit_clear      [N]    per-slot clear pulse from the collision unit
//   playerBulletState    [N]         bit i = slot i active
//   playerBulletPosition [N*SLOT_W]  slot i = {y[8:0], x[9:0]} at bit 19*i
//   fire_accepted         one-cycle pulse, aligned with the spawned bullet
// -----------------------------------------------------------------------------
module player_bullet_ctrl
  import galaga_pkg::SLOT_W, galaga_pkg::X_W, galaga_pkg::Y_W,
         galaga_pkg::BULLET_HEIGHT, galaga_pkg::bullet_fsm_e,
         galaga_pkg::S_READY, galaga_pkg::S_COOLDOWN, galaga_pkg::S_DEAD;
#(
  parameter int N_BULLETS       = 15,
  parameter int SPEED           = 8,
  parameter int COOLDOWN_FRAMES = 6,
  parameter int PLAYER_Y        = galaga_pkg::PLAYER_Y,
  parameter int X_MAX           = 636
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_tick,
  input  logic                          fire,
  input  logic                          playerState,
  input  logic [X_W-1:0]                playerPosition,
  input  logic [N_BULLETS-1:0]          hit_clear,
  output logic [N_BULLETS-1:0]          playerBulletState,
  output logic [N_BULLETS*SLOT_W-1:0]   playerBulletPosition,
  output logic                          fire_accepted
);

  localparam int IDX_W = (N_BULLETS > 1) ? $clog2(N_BULLETS) : 1;
  localparam int CNT_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

  localparam logic [Y_W-1:0] SPAWN_Y = Y_W'(PLAYER_Y - BULLET_HEIGHT);
  localparam logic [Y_W-1:0] SPEED_Y = Y_W'(SPEED);
  localparam logic [X_W:0]   X_SAT   = (X_W + 1)'(X_MAX);

  bullet_fsm_e                   r_state, w_state_nxt;
  logic [CNT_W-1:0]              r_cnt, w_cnt_nxt;
  logic                          r_pending, w_pending_nxt;
  logic                          r_fire_d;
  logic                          r_fire_acc;
  logic                          w_fire_req;
  logic                          w_spawn;

  logic [N_BULLETS-1:0]          r_act;
  logic [N_BULLETS-1:0][X_W-1:0] r_x;
  logic [N_BULLETS-1:0][Y_W-1:0] r_y;

  logic [N_BULLETS-1:0]          w_free;
  logic                          w_found;
  logic [IDX_W-1:0]              w_idx;

  logic [X_W:0]                  w_xsum;
  logic [X_W-1:0]                w_spawn_x;

  // ---------------------------------------------------------------------------
  // Fire request
  // ---------------------------------------------------------------------------
`ifdef PLAYER_BULLET_AUTOFIRE_EN
  assign w_fire_req = fire;
`else
  assign w_fire_req = fire & ~r_fire_d;
`endif

  // ---------------------------------------------------------------------------
  // Slot allocation. A slot retiring on this tick was active before the edge,
  // so masking with ~r_act already keeps it out of the candidate set. A slot
  // being cleared this cycle is excluded because the clear wins.
  // ---------------------------------------------------------------------------
  assign w_free = ~r_act & ~hit_clear;

  free_slot_finder #(
    .N     (N_BULLETS),
    .IDX_W (IDX_W)
  ) u_free (
    .i_free  (w_free),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  // Spawn x: sum in one extra bit so the saturation compare cannot wrap.
  assign w_xsum    = {1'b0, playerPosition} + (X_W + 1)'(10);
  assign w_spawn_x = (w_xsum > X_SAT) ? X_SAT[X_W-1:0] : w_xsum[X_W-1:0];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_READY;
      r_cnt      <= '0;
      r_pending  <= 1'b0;
      r_fire_d   <= 1'b0;
      r_fire_acc <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pending  <= w_pending_nxt;
      r_fire_d   <= fire;
      r_fire_acc <= w_spawn;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state, cooldown counter, pending shot, spawn strobe
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pending_nxt = r_pending;
    w_spawn       = 1'b0;

    if (!playerState) begin
      w_state_nxt   = S_DEAD;
      w_cnt_nxt     = '0;
      w_pending_nxt = 1'b0;
    end else begin
      case (r_state)
        S_READY: begin
          // A tick consumes the pending shot whether or not a slot is free;
          // a full pool simply drops it and stays READY.
          if (frame_tick && r_pending) begin
            w_pending_nxt = 1'b0;
            if (w_found) begin
              w_spawn     = 1'b1;
              w_state_nxt = S_COOLDOWN;
              w_cnt_nxt   = CNT_W'(COOLDOWN_FRAMES);
            end
          end
          // Applied after the consume so a request arriving on a tick is
          // held for the following tick.
          if (w_fire_req) begin
            w_pending_nxt = 1'b1;
          end
        end
        S_COOLDOWN: begin
          if (frame_tick) begin
            if (r_cnt <= CNT_W'(1)) begin
              w_state_nxt = S_READY;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt - CNT_W'(1);
            end
          end
        end
        S_DEAD: begin
          w_state_nxt = S_READY;
        end
        default: begin
          w_state_nxt = S_READY;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Per-slot state and position. hit_clear has top priority; a freshly
  // spawned bullet is not moved on its spawn tick.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_act <= '0;
      r_x   <= '0;
      r_y   <= '0;
    end else begin
      for (int i = 0; i < N_BULLETS; i++) begin
        if (hit_clear[i]) begin
          r_act[i] <= 1'b0;
          r_x[i]   <= '0;
          r_y[i]   <= '0;
        end else if (frame_tick) begin
          if (r_act[i]) begin
            if (r_y[i] < SPEED_Y) begin
              r_act[i] <= 1'b0;
              r_x[i]   <= '0;
              r_y[i]   <= '0;
            end else begin
              r_y[i] <= r_y[i] - SPEED_Y;
            end
          end else if (w_spawn && (w_idx == IDX_W'(i))) begin
            r_act[i] <= 1'b1;
            r_x[i]   <= w_spawn_x;
            r_y[i]   <= SPAWN_Y;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign playerBulletState = r_act;
  assign fire_accepted     = r_fire_acc;

  for (genvar g = 0; g < N_BULLETS; g++) begin : g_pack
    assign playerBulletPosition[g*SLOT_W +: SLOT_W] = {r_y[g], r_x[g]};
  end

endmodule

// File: tb/tb_player_bullet_ctrl.sv
// -----------------------------------------------------------------------------
// tb_player_bullet_ctrl
// Two instances share clock, reset and frame_tick: u_dut (default parameters)
// and u_dut2 (SPEED=1, so bullets live long enough to fill the whole pool).
// Each expected spawn is queued by the stimulus; a negedge monitor pops and
// checks it whenever the matching instance raises fire_accepted.
// -----------------------------------------------------------------------------
module tb_player_bullet_ctrl;
  import galaga_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n, frame_tick, fire, fire2, playerState;
  logic [9:0]    playerPosition;
  logic [14:0]   hit_clear, hit2;
  logic [14:0]   st1, st2;
  logic [284:0]  pos1, pos2;
  logic          fa1, fa2;

  always #5 clk = ~clk;

  player_bullet_ctrl u_dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .frame_tick           (frame_tick),
    .fire                 (fire),
    .playerState          (playerState),
    .playerPosition       (playerPosition),
    .hit_clear            (hit_clear),
    .playerBulletState    (st1),
    .playerBulletPosition (pos1),
    .fire_accepted        (fa1)
  );

  player_bullet_ctrl #(.SPEED(1)) u_dut2 (
    .clk                  (clk),
    .rst_n                (rst_n),
    .frame_tick           (frame_tick),
    .fire                 (fire2),
    .playerState          (playerState),
    .playerPosition       (playerPosition),
    .hit_clear            (hit2),
    .playerBulletState    (st2),
    .playerBulletPosition (pos2),
    .fire_accepted        (fa2)
  );

  typedef struct {
    int tick;
    int slot;
    int x;
    int y;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   tick_no = 0;

  function automatic int fx(input logic [284:0] p, input int s);
    logic [9:0] v;
    v = p[s*19 +: 10];
    return int'(v);
  endfunction

  function automatic int fy(input logic [284:0] p, input int s);
    logic [8:0] v;
    v = p[s*19+10 +: 9];
    return int'(v);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cmp_spawn(input string tag, input exp_t e,
                           input logic [14:0] st, input logic [284:0] p);
    chk({tag, " spawn tick"},  tick_no,            e.tick);
    chk({tag, " spawn state"}, int'(st[e.slot]),   1);
    chk({tag, " spawn x"},     fx(p, e.slot),      e.x);
    chk({tag, " spawn y"},     fy(p, e.slot),      e.y);
  endtask

  // Monitor: every fire_accepted pulse must match the oldest queued spawn.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (fa1 === 1'b1) begin
        if (q1.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL dut1 unexpected fire_accepted at tick %0d: got 1 expected 0", tick_no);
        end else begin
          cmp_spawn("dut1", q1.pop_front(), st1, pos1);
        end
      end
      if (fa2 === 1'b1) begin
        if (q2.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL dut2 unexpected fire_accepted at tick %0d: got 1 expected 0", tick_no);
        end else begin
          cmp_spawn("dut2", q2.pop_front(), st2, pos2);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One frame: a tick cycle followed by one idle cycle.
  task automatic tick();
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    tick_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic fire_edge();
    fire = 1'b1;
    cyc(1);
    fire = 1'b0;
    cyc(1);
  endtask

  task automatic fire2_edge();
    fire2 = 1'b1;
    cyc(1);
    fire2 = 1'b0;
    cyc(1);
  endtask

  task automatic push1(input int t, input int s, input int x, input int y);
    exp_t e;
    e = '{t, s, x, y};
    q1.push_back(e);
  endtask

  task automatic push2(input int t, input int s, input int x, input int y);
    exp_t e;
    e = '{t, s, x, y};
    q2.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    frame_tick     = 1'b0;
    fire           = 1'b0;
    fire2          = 1'b0;
    playerState    = 1'b1;
    playerPosition = 10'd100;
    hit_clear      = '0;
    hit2           = '0;
    cyc(2);

    // Reset values
    chk("reset state",    int'(st1), 0);
    chk("reset position", int'(|pos1), 0);
    chk("reset accepted", int'(fa1), 0);
    chk("reset state2",   int'(st2), 0);
    rst_n = 1'b1;
    cyc(1);

    // First shot: slot 0 at x=110, y=264 on tick 1
    fire_edge();
    push1(1, 0, 110, 264);
    tick();
    chk("first shot state", int'(st1), 1);
    chk("accepted one cycle", int'(fa1), 0);
    repeat (3) tick();
    chk("y after 3 ticks", fy(pos1, 0), 240);
    chk("x after 3 ticks", fx(pos1, 0), 110);

    // Edges every frame: cooldown allows spawns only at ticks 8 and 15
    for (int t = 5; t <= 15; t++) begin
      fire_edge();
      if (t == 8)  push1(8, 1, 110, 264);
      if (t == 15) push1(15, 2, 110, 264);
      tick();
    end
    chk("three slots active", int'(st1), 32'h7);

    // Slot 0 reaches y=0 at tick 34 and retires at tick 35
    repeat (19) tick();
    chk("slot0 at y=0 still active", int'(st1[0]), 1);
    chk("slot0 y=0", fy(pos1, 0), 0);
    playerPosition = 10'd200;
    fire_edge();
    push1(35, 3, 210, 264);   // slot 0 retires this tick, so not reused
    tick();
    chk("retire and skip state", int'(st1), 32'hE);
    chk("retired slot x zero", fx(pos1, 0), 0);
    chk("slot1 y at tick 35", fy(pos1, 1), 48);

    // X saturation: 635 + 10 clamps to 636; slot 1 retires on this tick
    repeat (6) tick();
    playerPosition = 10'd635;
    fire_edge();
    push1(42, 0, 636, 264);
    tick();
    chk("saturation state", int'(st1), 32'hD);

    // Player dies: bullets keep moving, fire ignored, pending discarded
    playerState    = 1'b0;
    playerPosition = 10'd100;
    cyc(1);
    tick();
    chk("dead bullet moves", fy(pos1, 0), 256);
    fire_edge();
    tick();
    playerState = 1'b1;
    cyc(1);
    tick();                   // tick 45: nothing pending after revival
    fire_edge();
    push1(46, 1, 110, 264);   // no cooldown left over from before death
    tick();
    chk("revived spawn state", int'(st1), 32'hF);

    // Fire edge on the same cycle as a tick spawns on the next tick
    repeat (6) tick();
    fire       = 1'b1;
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    fire       = 1'b0;
    frame_tick = 1'b0;
    tick_no++;
    cyc(1);
    push1(54, 2, 110, 264);
    tick();
    chk("same-cycle edge state", int'(st1), 32'hF);

    // Pool full on the SPEED=1 instance: 15 spawns 7 ticks apart
    for (int k = 0; k < 15; k++) begin
      fire2_edge();
      push2(tick_no + 1, k, 110, 264);
      tick();
      if (k < 14) repeat (6) tick();
    end
    repeat (6) tick();
    fire2_edge();
    tick();                   // full pool: shot dropped
    chk("pool full state", int'(st2), 32'h7FFF);
    chk("pool slot0 y", fy(pos2, 0), 159);
    hit2 = 15'h0004;
    cyc(1);
    hit2 = '0;
    chk("hit clear state", int'(st2), 32'h7FFB);
    chk("hit clear x", fx(pos2, 2), 0);
    fire2_edge();
    push2(tick_no + 1, 2, 110, 264);  // only spawns if FSM stayed READY
    tick();
    chk("refill state", int'(st2), 32'h7FFF);

    // Reset with bullets in flight
    rst_n = 1'b0;
    cyc(1);
    chk("mid-flight reset state2", int'(st2), 0);
    chk("mid-flight reset pos2", int'(|pos2), 0);
    rst_n = 1'b1;
    cyc(1);

    // Fire held for 20 ticks
    fire = 1'b1;
    cyc(1);
    push1(tick_no + 1, 0, 110, 264);
`ifdef PLAYER_BULLET_AUTOFIRE_EN
    push1(tick_no + 8, 1, 110, 264);
    push1(tick_no + 15, 2, 110, 264);
`endif
    repeat (20) tick();
    fire = 1'b0;
    cyc(2);

    chk("dut1 spawns outstanding", q1.size(), 0);
    chk("dut2 spawns outstanding", q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
